// File: rtl/bch_sched_pkg.sv
// Shared definitions for the BCH key-equation scheduler.
//   sched_state_e : scheduler FSM states
//   chw_of()      : width of a channel index for a given channel count
package bch_sched_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_KEY = 2'd2,
    HANDOFF  = 2'd3
  } sched_state_e;

  // Channel index width; never narrower than one bit.
  function automatic int chw_of(input int channels);
    return (channels < 2) ? 1 : $clog2(channels);
  endfunction

endpackage

// File: rtl/bch_key_sched_if.sv
// Bundle of the scheduler's data/handshake signals.
//   syn_done/syn_syndromes : per-channel syndrome capture (one-cycle pulse)
//   key_*                  : shared key-equation solver handshake
//   err_*                  : downstream error-stage handshake
//   overrun, busy          : status
// Handshake semantics: a start (key_start, err_start) is a one-cycle pulse
// issued only while the receiver's ready (key_ready, err_ready) is high.
// key_done is held high by the solver until the one-cycle key_ack_done,
// which always coincides with err_start.
// Modports: slave = scheduler side, master = surrounding environment.
interface bch_key_sched_if #(
  parameter int CHANNELS  = 2,
  parameter int SYN_WIDTH = 24
);
  localparam int CHW = bch_sched_pkg::chw_of(CHANNELS);

  logic [CHANNELS-1:0]           syn_done;
  logic [CHANNELS*SYN_WIDTH-1:0] syn_syndromes;
  logic                          key_ready;
  logic                          key_start;
  logic [SYN_WIDTH-1:0]          key_syndromes;
  logic                          key_done;
  logic                          key_ack_done;
  logic                          err_ready;
  logic                          err_start;
  logic [CHW-1:0]                err_chan;
  logic [CHANNELS-1:0]           overrun;
  logic                          busy;

  modport slave (
    input  syn_done, syn_syndromes, key_ready, key_done, err_ready,
    output key_start, key_syndromes, key_ack_done, err_start, err_chan,
           overrun, busy
  );

  modport master (
    output syn_done, syn_syndromes, key_ready, key_done, err_ready,
    input  key_start, key_syndromes, key_ack_done, err_start, err_chan,
           overrun, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : request vector
//   last  : index of the previous winner; search starts at last+1 mod N
//   grant : one-hot winner
//   idx   : winner index
//   valid : some request was granted
module rr_arbiter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         valid
);

  logic [W-1:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = '0;
    // Walk the ring starting just after the last winner; first hit wins.
    for (int i = 1; i <= N; i++) begin
      pos = W'((int'(last) + i) % N);
      if (!valid && req[pos]) begin
        valid      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/bch_key_sched.sv
// Round-robin scheduler sharing one serial key-equation solver between
// several syndrome engines. Captures syndromes per channel, issues one
// solver job at a time, and hands each result to the error stage tagged
// with its channel.
//   clk, reset : clock, synchronous active-high reset
//   bus        : data/handshake bundle (slave side)
//   dbg_state  : current FSM state
module bch_key_sched
  import bch_sched_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int SYN_WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  bch_key_sched_if.slave   bus,
  output sched_state_e     dbg_state
);

  localparam int CHW = chw_of(CHANNELS);

  sched_state_e         state_q, state_d;
  logic [CHANNELS-1:0]  pending_q;
  logic [CHANNELS-1:0]  overrun_q;
  logic [SYN_WIDTH-1:0] hold_q [CHANNELS];
  logic [CHW-1:0]       last_q;
  logic [CHW-1:0]       tag_q;
  logic [CHW-1:0]       err_chan_q;
  logic [SYN_WIDTH-1:0] key_syn_q;

  logic [CHANNELS-1:0]  arb_grant;
  logic [CHW-1:0]       arb_idx;
  logic                 arb_valid;

  logic                 grant_fire;
  logic                 handoff_go;
  logic [CHANNELS-1:0]  grant_clr;
  logic [CHANNELS-1:0]  cap_ok;

  rr_arbiter #(.N(CHANNELS), .W(CHW)) u_arb (
    .req   (pending_q),
    .last  (last_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign grant_fire = (state_q == IDLE) && bus.key_ready && arb_valid;
  // Outputs are gated by reset so an aborted job never fires downstream.
  assign handoff_go = (state_q == HANDOFF) && bus.err_ready && !reset;
  assign grant_clr  = grant_fire ? arb_grant : '0;
  // A channel whose pending bit is cleared by this cycle's grant may take
  // new syndromes without counting as an overrun.
  assign cap_ok     = bus.syn_done & (~pending_q | grant_clr);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (grant_fire) state_d = ISSUE;
      ISSUE:    state_d = WAIT_KEY;
      WAIT_KEY: if (bus.key_done) state_d = HANDOFF;
      HANDOFF:  if (bus.err_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      overrun_q  <= '0;
      last_q     <= CHW'(CHANNELS - 1);
      tag_q      <= '0;
      err_chan_q <= '0;
      key_syn_q  <= '0;
      for (int c = 0; c < CHANNELS; c++) hold_q[c] <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= (pending_q & ~grant_clr) | cap_ok;
      overrun_q <= overrun_q | (bus.syn_done & ~cap_ok);
      for (int c = 0; c < CHANNELS; c++) begin
        if (cap_ok[c]) hold_q[c] <= bus.syn_syndromes[c*SYN_WIDTH +: SYN_WIDTH];
      end
      if (grant_fire) begin
        key_syn_q <= hold_q[arb_idx];
        tag_q     <= arb_idx;
        last_q    <= arb_idx;
      end
      if (handoff_go) err_chan_q <= tag_q;
    end
  end

  assign bus.key_start     = (state_q == ISSUE) && !reset;
  assign bus.key_syndromes = key_syn_q;
  assign bus.key_ack_done  = handoff_go;
  assign bus.err_start     = handoff_go;
  // err_chan shows the new tag in the same cycle as err_start.
  assign bus.err_chan      = handoff_go ? tag_q : err_chan_q;
  assign bus.overrun       = overrun_q;
  assign bus.busy          = (|pending_q) || (state_q != IDLE);
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_bch_key_sched.sv
module tb_bch_key_sched;
  import bch_sched_pkg::*;

  localparam int CH = 2;
  localparam int SW = 24;
  localparam int CW = 1;
  localparam int EW = CW + SW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sched_state_e dbg_state;
  bch_key_sched_if #(.CHANNELS(CH), .SYN_WIDTH(SW)) bus();

  bch_key_sched #(.CHANNELS(CH), .SYN_WIDTH(SW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];   // {channel, syndromes} in expected issue order
  logic [CW-1:0] chan_q[$];  // channels issued, awaiting err_start
  logic [EW-1:0] cur;
  logic          prev_start = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.key_start) begin
        chk("key_start_one_cycle", prev_start, 1'b0);
        chk("key_start_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          chk("key_syndromes", bus.key_syndromes, cur[SW-1:0]);
          chan_q.push_back(cur[EW-1:SW]);
        end
      end
      if (bus.err_start || bus.key_ack_done) begin
        chk("ack_with_err_start", bus.key_ack_done, bus.err_start);
        chk("err_start_expected", chan_q.size() != 0, 1'b1);
        if (chan_q.size() != 0) chk("err_chan", bus.err_chan, chan_q.pop_front());
      end
    end
    prev_start = bus.key_start;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [1:0] mask, input logic [SW-1:0] d0, input logic [SW-1:0] d1);
    bus.syn_done      = mask;
    bus.syn_syndromes = {d1, d0};
    tick();
    bus.syn_done = '0;
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (bus.key_start !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk(tag, bus.key_start, 1'b1);
  endtask

  // Completes the job in flight: key_done after 'delay' cycles, err_ready
  // held low for 'bp' cycles from key_done.
  task automatic finish_job(input int delay, input int bp);
    repeat (delay) tick();
    bus.key_done  = 1'b1;
    bus.err_ready = (bp == 0);
    #1;
    chk("no_ack_before_handoff", bus.key_ack_done, 1'b0);
    tick();
    for (int i = 0; i < bp; i++) begin
      #1;
      chk("bp_err_start_held", bus.err_start, 1'b0);
      chk("bp_state_handoff", dbg_state, HANDOFF);
      tick();
    end
    bus.err_ready = 1'b1;
    #1;
    chk("err_start", bus.err_start, 1'b1);
    chk("key_ack_done", bus.key_ack_done, 1'b1);
    tick();
    bus.key_done = 1'b0;
    #1;
    chk("err_start_one_cycle", bus.err_start, 1'b0);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.key_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.syn_done      = '0;
    bus.syn_syndromes = '0;
    bus.key_ready     = 1'b1;
    bus.key_done      = 1'b0;
    bus.err_ready     = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("rst_key_start", bus.key_start, 1'b0);
    chk("rst_key_syndromes", bus.key_syndromes, 24'h0);
    chk("rst_key_ack_done", bus.key_ack_done, 1'b0);
    chk("rst_err_start", bus.err_start, 1'b0);
    chk("rst_err_chan", bus.err_chan, 1'b0);
    chk("rst_overrun", bus.overrun, 2'b00);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_state", dbg_state, IDLE);

    // Single job: key_start two cycles after syn_done.
    tick();
    exp_q.push_back({1'b0, 24'hABCDEF});
    pulse(2'b01, 24'hABCDEF, 24'h0);
    chk("t1_busy", bus.busy, 1'b1);
    chk("t1_no_early_start", bus.key_start, 1'b0);
    tick();
    chk("t1_start_latency", bus.key_start, 1'b1);
    chk("t1_key_syndromes", bus.key_syndromes, 24'hABCDEF);
    finish_job(32, 0);
    chk("t1_err_chan_hold", bus.err_chan, 1'b0);
    chk("t1_idle_busy", bus.busy, 1'b0);

    // Fairness from reset: 0,1,0,1.
    do_reset();
    exp_q.push_back({1'b0, 24'h000A01});
    exp_q.push_back({1'b1, 24'h000B01});
    pulse(2'b11, 24'h000A01, 24'h000B01);
    wait_start("fair_start0"); finish_job(3, 0);
    wait_start("fair_start1"); finish_job(3, 0);
    exp_q.push_back({1'b0, 24'h000A02});
    exp_q.push_back({1'b1, 24'h000B02});
    pulse(2'b11, 24'h000A02, 24'h000B02);
    wait_start("fair_start2"); finish_job(5, 0);
    wait_start("fair_start3"); finish_job(2, 0);
    chk("fair_overrun", bus.overrun, 2'b00);

    // Overrun on channel 1 while channel 0 is being solved.
    exp_q.push_back({1'b0, 24'h0A0A0A});
    pulse(2'b01, 24'h0A0A0A, 24'h0);
    wait_start("ovr_start0");
    exp_q.push_back({1'b1, 24'h111111});
    pulse(2'b10, 24'h0, 24'h111111);
    pulse(2'b10, 24'h0, 24'h222222);
    chk("ovr_flag", bus.overrun, 2'b10);
    finish_job(6, 0);
    wait_start("ovr_start1");
    chk("ovr_kept_old", bus.key_syndromes, 24'h111111);
    finish_job(4, 0);
    chk("ovr_sticky", bus.overrun, 2'b10);
    chk("ovr_idle", bus.busy, 1'b0);

    // key_ready low blocks the grant; then capture in the grant cycle.
    bus.key_ready = 1'b0;
    exp_q.push_back({1'b0, 24'h0DD001});
    pulse(2'b01, 24'h0DD001, 24'h0);
    repeat (3) begin
      chk("blocked_no_start", bus.key_start, 1'b0);
      chk("blocked_state", dbg_state, IDLE);
      tick();
    end
    chk("blocked_busy", bus.busy, 1'b1);
    bus.key_ready = 1'b1;
    exp_q.push_back({1'b0, 24'h0EE002});
    pulse(2'b01, 24'h0EE002, 24'h0);
    chk("same_cycle_start", bus.key_start, 1'b1);
    chk("same_cycle_old", bus.key_syndromes, 24'h0DD001);
    chk("same_cycle_busy", bus.busy, 1'b1);
    finish_job(4, 0);
    wait_start("same_cycle_new_start");
    finish_job(3, 0);
    chk("same_cycle_overrun", bus.overrun, 2'b10);

    // Backpressure with a second job waiting (last winner was 0 -> 1 first).
    exp_q.push_back({1'b1, 24'h00BB11});
    exp_q.push_back({1'b0, 24'h00AA00});
    pulse(2'b11, 24'h00AA00, 24'h00BB11);
    wait_start("bp_start_a");
    finish_job(5, 20);
    wait_start("bp_start_b");
    finish_job(3, 0);

    // Reset while waiting on the solver with channel 1 pending.
    exp_q.push_back({1'b0, 24'h123456});
    pulse(2'b01, 24'h123456, 24'h0);
    wait_start("rst_job_start");
    tick();
    pulse(2'b10, 24'h0, 24'h654321);
    chk("rst_mid_state", dbg_state, WAIT_KEY);
    chk("rst_mid_busy", bus.busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chan_q.delete();
    #1;
    chk("abort_key_start", bus.key_start, 1'b0);
    chk("abort_key_syndromes", bus.key_syndromes, 24'h0);
    chk("abort_key_ack", bus.key_ack_done, 1'b0);
    chk("abort_err_start", bus.err_start, 1'b0);
    chk("abort_err_chan", bus.err_chan, 1'b0);
    chk("abort_overrun", bus.overrun, 2'b00);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_state", dbg_state, IDLE);
    repeat (20) tick();
    chk("abort_stays_idle", bus.busy, 1'b0);

    chk("exp_q_drained", exp_q.size(), 0);
    chk("chan_q_drained", chan_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bch_key_sched.md
# bch_key_sched

Round-robin scheduler that shares one serial key-equation solver (`bch_sigma_bma_serial`) between several independent syndrome engines in a multi-channel BCH decoder. It captures each channel's syndromes on `syn_done` and queues the channel. It then issues one key-equation job at a time to the shared solver. When the solver finishes, it hands the result to the downstream Chien/error stage, tagged with the originating channel. It sits between the per-channel `bch_syndrome` instances and the shared `bch_sigma_bma_serial` / `bch_error_tmec` pair.

## Interface
- `CHANNELS`, 2: number of syndrome engines sharing the solver; range 2..8.
- `SYN_WIDTH`, 24: width of one channel's syndrome bus (`BCH_SYNDROMES_SZ` of the shared parameter set).
- `CHW`, derived as clog2(CHANNELS): width of a channel index.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `syn_done` in CHANNELS: one-cycle pulse per channel; its syndromes are valid that cycle.
- `syn_syndromes` in CHANNELS*SYN_WIDTH: channel c occupies bits [c*SYN_WIDTH +: SYN_WIDTH].
- `key_ready` in 1: solver idle and able to accept a start.
- `key_start` out 1: one-cycle start pulse to the solver.
- `key_syndromes` out SYN_WIDTH: syndromes of the granted job. Stable from `key_start` until the job is acked.
- `key_done` in 1: solver result valid; held high until `key_ack_done`.
- `key_ack_done` out 1: one-cycle acknowledge to the solver.
- `err_ready` in 1: error stage can accept a new `start`.
- `err_start` out 1: one-cycle start to the error stage.
- `err_chan` out CHW: channel of the current/last error-stage job. Holds until the next `err_start`.
- `overrun` out CHANNELS: sticky per-channel drop flag, cleared only by `reset`.
- `busy` out 1: high when any job is pending or in flight.

## Operation
- Per-channel holding register `hold[c]` (SYN_WIDTH) and `pending[c]` bit.
- Capture when `syn_done[c]`:
  - If `pending[c]`=0, load `hold[c]` and set `pending[c]`.
  - If `pending[c]`=1, drop the new syndromes, keep the old ones, and set `overrun[c]`.
  - Exception: if the grant clears `pending[c]` in the same cycle, capture the new syndromes normally with no overrun.
- Round-robin grant: search starts at `last+1` mod CHANNELS and takes the first pending channel. `last` updates to the granted channel.
- FSM states:
  - IDLE: if `key_ready` and any `pending`, grant. On grant, load `key_syndromes` from the hold register, latch `tag`, clear `pending[grant]`, and go to ISSUE.
  - ISSUE: assert `key_start` for one cycle, then go to WAIT_KEY.
  - WAIT_KEY: when `key_done`=1, go to HANDOFF.
  - HANDOFF: when `err_ready`=1, assert `err_start` and `key_ack_done` together for one cycle, load `err_chan`=`tag`, and go to IDLE.
- Exactly one job is in flight at a time. `key_start` is never asserted outside ISSUE.
- `busy` = |pending or state≠IDLE.

## Timing
- Reset values: every output 0; `pending`=0; `overrun`=0; `last`=CHANNELS-1, so channel 0 wins first; state IDLE.
- `syn_done[c]` at cycle t gives `pending[c]` at t+1. With an idle solver: grant at t+1, `key_start` at t+2.
- `key_done` first seen at cycle k: HANDOFF at k+1. `err_start`/`key_ack_done` at k+1 if `err_ready`, otherwise the first later cycle with `err_ready`=1.
- Back to IDLE at k+2. The next `key_start` comes no earlier than k+3.
- A `key_ready` deassert in IDLE blocks the grant; pending channels wait with no loss.
- `reset` mid-job:
  - Returns to IDLE next cycle and discards all pending and in-flight jobs.
  - No `err_start` for an aborted job.
  - The solver and error stage are reset by the same `reset`.

## Structure
- Shared package `bch_sched_pkg`: FSM state enum (IDLE, ISSUE, WAIT_KEY, HANDOFF) and a `clog2`-based CHW helper.
- One sub-module `rr_arbiter` (CHANNELS-wide request/`last` pointer → one-hot grant plus index, combinational). It is reusable for the error-stage sharing planned next.
- Capture registers and FSM stay in `bch_key_sched`.

## Test plan
- Single job: CHANNELS=2, `syn_done[0]` at t=5 with syndromes 0xABCDEF, `key_ready`=1. Expect `key_start` at t=7 with `key_syndromes`=0xABCDEF. Then `key_done` at t=40 with `err_ready`=1. Expect `err_start`, `key_ack_done` and `err_chan`=0 at t=41.
- Fairness: both channels pulse `syn_done` at the same cycle, then repeat after each job. Expect grants in order 0,1,0,1 and no `overrun`.
- Overrun: `syn_done[1]` twice (0x111111, then 0x222222) while the solver is busy with channel 0. Expect `overrun`=2'b10 and a channel-1 job with `key_syndromes`=0x111111; `overrun` stays set.
- Same-cycle capture/grant: `syn_done[0]` in the exact cycle channel 0 is granted. Expect the old syndromes issued, the new syndromes pending, and `overrun[0]`=0.
- Backpressure: hold `err_ready`=0 for 20 cycles after `key_done`. Expect `key_ack_done`/`err_start` withheld, then asserted together for one cycle the cycle `err_ready` rises. No second `key_start` meanwhile.
- Reset in WAIT_KEY with channel 1 pending. Expect all outputs 0 next cycle, `busy`=0, and no `err_start` afterwards.
